// File: rtl/entropy_src_shutdown_seq.sv
// Enable / orderly-shutdown sequencer for the entropy_src datapath: drain RNG FIFOs,
// wait for the SHA3 conditioner to go idle, then pulse a buffer clear before re-enable.
module entropy_src_shutdown_seq #(
  parameter int DrainTimeout = 4,
  parameter int ShaTimeout   = 64,
  parameter int ClearCycles  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic bypass_mode_i,
  input  logic esrng_not_empty_i,
  input  logic esbit_not_empty_i,
  input  logic postht_not_empty_i,
  input  logic distr_not_empty_i,
  input  logic sha_busy_i,
  output logic enable_o,
  output logic clear_o,
  output logic busy_o,
  output logic drain_timeout_o,
  output logic sha_timeout_err_o,
  output logic fsm_err_o
);

  localparam int DrainW = $clog2(DrainTimeout + 1);
  localparam int ShaW   = $clog2(ShaTimeout + 1);
  localparam int ClrW   = $clog2(ClearCycles + 1);

  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainTimeout - 1);
  localparam logic [ShaW-1:0]   ShaLast   = ShaW'(ShaTimeout - 1);
  localparam logic [ClrW-1:0]   ClrLast   = ClrW'(ClearCycles - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACTIVE   = 3'd1,
    DRAIN    = 3'd2,
    SHA_WAIT = 3'd3,
    CLEAR    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [ShaW-1:0]   sha_cnt_q, sha_cnt_d;
  logic [ClrW-1:0]   clr_cnt_q, clr_cnt_d;
  logic              drain_tmo_q, drain_tmo_d;
  logic              sha_err_q, sha_err_d;
  logic              fsm_err_q, fsm_err_d;
  logic              empty;

  // In bypass mode the post-health-test and distribution FIFOs are not in the data path.
  assign empty = ~esrng_not_empty_i & ~esbit_not_empty_i &
                 (bypass_mode_i | (~postht_not_empty_i & ~distr_not_empty_i));

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    sha_cnt_d   = sha_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    drain_tmo_d = 1'b0;
    sha_err_d   = sha_err_q;
    fsm_err_d   = fsm_err_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!enable_i) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        // An empty pipeline takes priority over a coincident timeout.
        if (empty || drain_cnt_q == DrainLast) begin
          drain_tmo_d = ~empty;
          if (sha_busy_i) begin
            state_d   = SHA_WAIT;
            sha_cnt_d = '0;
          end else begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      SHA_WAIT: begin
        if (!sha_busy_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (sha_cnt_q == ShaLast) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          sha_err_d = 1'b1;
        end else begin
          sha_cnt_d = sha_cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == ClrLast) state_d = IDLE;
        else                      clr_cnt_d = clr_cnt_q + 1'b1;
      end
      default: begin
        // Corrupted state: force a clean clear so the core restarts from a known point.
        state_d   = CLEAR;
        clr_cnt_d = '0;
        fsm_err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      sha_cnt_q   <= '0;
      clr_cnt_q   <= '0;
      drain_tmo_q <= 1'b0;
      sha_err_q   <= 1'b0;
      fsm_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      sha_cnt_q   <= sha_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      drain_tmo_q <= drain_tmo_d;
      sha_err_q   <= sha_err_d;
      fsm_err_q   <= fsm_err_d;
    end
  end

  assign enable_o          = (state_q == ACTIVE) || (state_q == DRAIN);
  assign clear_o           = (state_q == CLEAR);
  assign busy_o            = (state_q == DRAIN) || (state_q == SHA_WAIT) || (state_q == CLEAR);
  assign drain_timeout_o   = drain_tmo_q;
  assign sha_timeout_err_o = sha_err_q;
  assign fsm_err_o         = fsm_err_q;

endmodule

// File: tb/tb_entropy_src_shutdown_seq.sv
// Scoreboard bench for entropy_src_shutdown_seq: the driver queues the expected output
// vector {enable,clear,busy,drain_tmo,sha_err,fsm_err} for each cycle; a monitor checks it.
module tb_entropy_src_shutdown_seq;

  logic clk = 1'b0;
  logic rst, en, byp, rng, bt, pht, dst, sha;
  logic enable_o, clear_o, busy_o, drain_timeout_o, sha_timeout_err_o, fsm_err_o;

  entropy_src_shutdown_seq #(
    .DrainTimeout(4),
    .ShaTimeout  (64),
    .ClearCycles (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (en),
    .bypass_mode_i     (byp),
    .esrng_not_empty_i (rng),
    .esbit_not_empty_i (bt),
    .postht_not_empty_i(pht),
    .distr_not_empty_i (dst),
    .sha_busy_i        (sha),
    .enable_o          (enable_o),
    .clear_o           (clear_o),
    .busy_o            (busy_o),
    .drain_timeout_o   (drain_timeout_o),
    .sha_timeout_err_o (sha_timeout_err_o),
    .fsm_err_o         (fsm_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at_cyc;
    logic [5:0]  exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].at_cyc <= cyc) begin
        logic [5:0] act;
        exp_t       e;
        e   = q.pop_front();
        act = {enable_o, clear_o, busy_o, drain_timeout_o, sha_timeout_err_o, fsm_err_o};
        checks++;
        if (act !== e.exp || e.at_cyc != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d: got %b expected %b (E C B D S F)", e.name, cyc, act, e.exp);
        end
      end
    end
  end

  // in = {rst,en,byp,rng,bit,pht,dst,sha}; exp = outputs after the next rising edge.
  task automatic step(input logic [7:0] in, input logic [5:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    {rst, en, byp, rng, bt, pht, dst, sha} = in;
    e.at_cyc = cyc + 1;
    e.exp    = exp;
    e.name   = nm;
    q.push_back(e);
  endtask

  initial begin
    {rst, en, byp, rng, bt, pht, dst, sha} = 8'b1000_0000;

    step(8'b1000_0000, 6'b000000, "reset");
    step(8'b0000_0000, 6'b000000, "idle_hold");

    // Clean shutdown: empty FIFOs, SHA idle.
    step(8'b0100_0000, 6'b100000, "t2_active");
    step(8'b0100_0000, 6'b100000, "t2_active_hold");
    step(8'b0000_0000, 6'b101000, "t2_drain");
    step(8'b0000_0000, 6'b011000, "t2_clear0");
    step(8'b0000_0000, 6'b011000, "t2_clear1");
    step(8'b0000_0000, 6'b000000, "t2_idle");

    // Drain timeout with esrng never empty.
    step(8'b0100_0000, 6'b100000, "t3_active");
    step(8'b0001_0000, 6'b101000, "t3_drain0");
    step(8'b0001_0000, 6'b101000, "t3_drain1");
    step(8'b0001_0000, 6'b101000, "t3_drain2");
    step(8'b0001_0000, 6'b101000, "t3_drain3");
    step(8'b0001_0000, 6'b011100, "t3_tmo_pulse");
    step(8'b0001_0000, 6'b011000, "t3_clear1");
    step(8'b0001_0000, 6'b000000, "t3_idle");

    // FIFO empties exactly at the timeout cycle: no pulse.
    step(8'b0100_0000, 6'b100000, "t3b_active");
    step(8'b0000_1000, 6'b101000, "t3b_drain0");
    step(8'b0000_1000, 6'b101000, "t3b_drain1");
    step(8'b0000_1000, 6'b101000, "t3b_drain2");
    step(8'b0000_1000, 6'b101000, "t3b_drain3");
    step(8'b0000_0000, 6'b011000, "t3b_empty_wins");
    step(8'b0000_0000, 6'b011000, "t3b_clear1");
    step(8'b0000_0000, 6'b000000, "t3b_idle");

    // Bypass: postht/distr occupancy ignored.
    step(8'b0110_0110, 6'b100000, "t4_active");
    step(8'b0010_0110, 6'b101000, "t4_drain");
    step(8'b0010_0110, 6'b011000, "t4_clear0");
    step(8'b0010_0110, 6'b011000, "t4_clear1");
    step(8'b0010_0110, 6'b000000, "t4_idle");
    // Same occupancy without bypass does not drain.
    step(8'b0100_0110, 6'b100000, "t4n_active");
    step(8'b0000_0110, 6'b101000, "t4n_drain0");
    step(8'b0000_0000, 6'b011000, "t4n_clear0");
    step(8'b0000_0000, 6'b011000, "t4n_clear1");
    step(8'b0000_0000, 6'b000000, "t4n_idle");

    // SHA stuck busy: 64 cycles in SHA_WAIT, then error.
    step(8'b0100_0001, 6'b100000, "t5_active");
    step(8'b0000_0001, 6'b101000, "t5_drain");
    step(8'b0000_0001, 6'b001000, "t5_sha0");
    for (int i = 1; i < 64; i++) step(8'b0000_0001, 6'b001000, "t5_sha_wait");
    step(8'b0000_0001, 6'b011010, "t5_err_clear0");
    step(8'b0000_0000, 6'b011010, "t5_clear1");
    step(8'b0000_0000, 6'b000010, "t5_idle_sticky");
    step(8'b0000_0000, 6'b000010, "t5_sticky_hold");

    // Reset while in SHA_WAIT clears everything including sticky error.
    step(8'b0100_0001, 6'b100010, "t1_active");
    step(8'b0000_0001, 6'b101010, "t1_drain");
    step(8'b0000_0001, 6'b001010, "t1_sha0");
    step(8'b0000_0001, 6'b001010, "t1_sha1");
    step(8'b1100_0001, 6'b000000, "t1_reset");
    step(8'b0000_0001, 6'b000000, "t1_idle");

    // Busy drops on the 64th SHA_WAIT cycle: no error.
    step(8'b0100_0001, 6'b100000, "t5b_active");
    step(8'b0000_0001, 6'b101000, "t5b_drain");
    step(8'b0000_0001, 6'b001000, "t5b_sha0");
    for (int i = 1; i < 64; i++) step(8'b0000_0001, 6'b001000, "t5b_sha_wait");
    step(8'b0000_0000, 6'b011000, "t5b_noerr_clear0");
    step(8'b0000_0000, 6'b011000, "t5b_clear1");
    step(8'b0000_0000, 6'b000000, "t5b_idle");

    // Re-enable during DRAIN is ignored until back in IDLE.
    step(8'b0100_0000, 6'b100000, "t6_active");
    step(8'b0001_0001, 6'b101000, "t6_drain0");
    step(8'b0101_0001, 6'b101000, "t6_drain1");
    step(8'b0100_0001, 6'b001000, "t6_sha0");
    step(8'b0100_0001, 6'b001000, "t6_sha1");
    step(8'b0100_0000, 6'b011000, "t6_clear0");
    step(8'b0100_0000, 6'b011000, "t6_clear1");
    step(8'b0100_0000, 6'b000000, "t6_idle");
    step(8'b0100_0000, 6'b100000, "t6_reenable");
    step(8'b0100_0000, 6'b100000, "t6_active_hold");

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
